// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master (core C, debug D) arbiter for the 16-bit peripheral bus
// Define MEM_BUS_ARB_RR_EN for round-robin contention; default is D priority with a burst cap.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cReq,
  input  logic        cWr,
  input  logic [15:0] cAddr,
  input  logic [15:0] cWdata,
  output logic        cAck,
  output logic [15:0] cRdata,
  input  logic        dReq,
  input  logic        dWr,
  input  logic [15:0] dAddr,
  input  logic [15:0] dWdata,
  output logic        dAck,
  output logic [15:0] dRdata,
  output logic [15:0] busAddr,
  inout  wire  [15:0] busData,
  output logic        busWr,
  output logic        busEn
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } arbStateT;

  arbStateT    state;
  logic        ownerD;
  logic        busDrive;
  logic [15:0] latWdata;
  logic        grantD;

`ifdef MEM_BUS_ARB_RR_EN
  logic lastGrantD;
`else
  localparam logic [3:0] BurstMax = 4'(MAX_BURST);
  logic [3:0] burstCnt;
`endif

  // busDrive is its own register so the tristate enable never glitches
  assign busData = busDrive ? latWdata : 16'hzzzz;

  always_comb begin
    grantD = dReq;
`ifdef MEM_BUS_ARB_RR_EN
    if (cReq && dReq) grantD = !lastGrantD;
`else
    if (cReq && dReq) grantD = (burstCnt != BurstMax);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busEn    <= 1'b0;
      busWr    <= 1'b0;
      busAddr  <= 16'h0000;
      busDrive <= 1'b0;
      latWdata <= 16'h0000;
      ownerD   <= 1'b0;
      cAck     <= 1'b0;
      dAck     <= 1'b0;
      cRdata   <= 16'h0000;
      dRdata   <= 16'h0000;
`ifdef MEM_BUS_ARB_RR_EN
      lastGrantD <= 1'b1;
`else
      burstCnt <= 4'd0;
`endif
    end else begin
      cAck <= 1'b0;
      dAck <= 1'b0;
      case (state)
        IDLE: begin
`ifndef MEM_BUS_ARB_RR_EN
          // counts D wins over a waiting C; any C grant or C-idle cycle restarts it
          if (!cReq || !grantD) burstCnt <= 4'd0;
          else if (burstCnt != BurstMax) burstCnt <= burstCnt + 4'd1;
`endif
          if (cReq || dReq) begin
            ownerD   <= grantD;
            busEn    <= 1'b1;
            busAddr  <= grantD ? dAddr : cAddr;
            busWr    <= grantD ? dWr : cWr;
            busDrive <= grantD ? dWr : cWr;
            latWdata <= grantD ? dWdata : cWdata;
`ifdef MEM_BUS_ARB_RR_EN
            lastGrantD <= grantD;
`endif
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          busEn    <= 1'b0;
          busWr    <= 1'b0;
          busDrive <= 1'b0;
          if (!busWr) begin
            if (ownerD) dRdata <= busData;
            else        cRdata <= busData;
          end
          if (ownerD) dAck <= 1'b1;
          else        cAck <= 1'b1;
          state <= TURN;
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed bench for mem_bus_arbiter against a transaction model
// Honours MEM_BUS_ARB_RR_EN to select the expected arbitration policy.
module tb_mem_bus_arbiter;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cReq = 1'b0, cWr = 1'b0, dReq = 1'b0, dWr = 1'b0;
  logic [15:0] cAddr = 16'h0, cWdata = 16'h0, dAddr = 16'h0, dWdata = 16'h0;
  logic        cAck, dAck, busWr, busEn;
  logic [15:0] cRdata, dRdata, busAddr;
  wire  [15:0] busData;

  int total = 0;
  int bad = 0;

  // master-side stimulus state: 0 idle, 1 requesting, 2 granted awaiting ack
  int          st[2];
  bit          mReq[2];
  bit          mWr[2];
  logic [15:0] mAddr[2];
  logic [15:0] mWdata[2];

  // transaction-level model
  int          cyc;
  bit          haveTx;
  int          g;
  bit          txD, txWr;
  logic [15:0] txAddr, txWdata;
  int          burst;
  bit          lastD;
  logic [15:0] cRdM, dRdM;
  int          order[$];

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rstn(rstn),
    .cReq(cReq), .cWr(cWr), .cAddr(cAddr), .cWdata(cWdata), .cAck(cAck), .cRdata(cRdata),
    .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWdata(dWdata), .dAck(dAck), .dRdata(dRdata),
    .busAddr(busAddr), .busData(busData), .busWr(busWr), .busEn(busEn)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] periphRead(input logic [15:0] a);
    if (a == 16'h0002) return 16'h1234;
    return {a[7:0] ^ 8'h5A, ~a[15:8]};
  endfunction

  assign busData = (busEn && !busWr) ? periphRead(busAddr) : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    cReq = mReq[0]; cWr = mWr[0]; cAddr = mAddr[0]; cWdata = mWdata[0];
    dReq = mReq[1]; dWr = mWr[1]; dAddr = mAddr[1]; dWdata = mWdata[1];
  endtask

  task automatic newReq(input int m);
    st[m]     = 1;
    mReq[m]   = 1'b1;
    mWr[m]    = 1'($urandom_range(0, 1));
    mAddr[m]  = ($urandom_range(0, 3) == 0) ? 16'h0002 : 16'($urandom);
    mWdata[m] = 16'($urandom);
  endtask

  task automatic setReq(input int m, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    st[m] = 1; mReq[m] = 1'b1; mWr[m] = wr; mAddr[m] = a; mWdata[m] = wd;
  endtask

  task automatic arbitrate();
    bit cR, dR, winD;
    cR = mReq[0];
    dR = mReq[1];
`ifdef MEM_BUS_ARB_RR_EN
    winD = (cR && dR) ? !lastD : dR;
`else
    winD = (cR && dR) ? (burst < MAX_BURST) : dR;
    if (cR && winD) burst = (burst < MAX_BURST) ? burst + 1 : burst;
    else            burst = 0;
`endif
    if (cR || dR) begin
      haveTx  = 1'b1;
      g       = cyc;
      txD     = winD;
      txWr    = mWr[winD];
      txAddr  = mAddr[winD];
      txWdata = mWdata[winD];
      st[winD] = 2;
      lastD   = winD;
    end
  endtask

  // keep=1: requests survive the reset (a granted one becomes pending again if still asserted)
  task automatic doReset(input bit keep);
    rstn = 1'b0;
    for (int m = 0; m < 2; m++) begin
      if (!keep || !mReq[m]) begin st[m] = 0; mReq[m] = 1'b0; end
      else st[m] = 1;
    end
    drive();
    haveTx = 1'b0; burst = 0; lastD = 1'b1; cRdM = 16'h0; dRdM = 16'h0; cyc = 0;
    repeat (2) begin
      @(negedge clk);
      check("rstBusEn", busEn, 1'b0);
      check("rstBusWr", busWr, 1'b0);
      check("rstBusAddr", busAddr, 16'h0);
      check("rstBusDataZ", busData, 16'hzzzz);
      check("rstAcks", {cAck, dAck}, 2'b00);
      check("rstRdata", {cRdata, dRdata}, 32'h0);
    end
    rstn = 1'b1;
  endtask

  // mode 0: random traffic, 1: both masters always requesting, 2: only preloaded requests
  task automatic runCycles(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      bit expEn, expC, expD;
      expEn = haveTx && (cyc == g + 1);
      expC  = haveTx && (cyc == g + 2) && !txD;
      expD  = haveTx && (cyc == g + 2) && txD;
      check("busEn", busEn, expEn);
      check("busWr", busWr, expEn && txWr);
      if (expEn) begin
        check("busAddr", busAddr, txAddr);
        check("busData", busData, txWr ? txWdata : periphRead(txAddr));
      end else begin
        check("busDataZ", busData, 16'hzzzz);
      end
      if ((expC || expD) && !txWr) begin
        if (txD) dRdM = periphRead(txAddr);
        else     cRdM = periphRead(txAddr);
      end
      check("cAck", cAck, expC);
      check("dAck", dAck, expD);
      check("cRdata", cRdata, cRdM);
      check("dRdata", dRdata, dRdM);
      if (cAck) order.push_back(0);
      if (dAck) order.push_back(1);
      if (expC || expD) begin st[txD] = 0; mReq[txD] = 1'b0; end
      for (int m = 0; m < 2; m++) begin
        case (st[m])
          0: if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) newReq(m);
          1: if (mode == 0 && $urandom_range(0, 15) == 0) begin st[m] = 0; mReq[m] = 1'b0; end
          2: if (mode == 0 && $urandom_range(0, 3) == 0) mReq[m] = 1'b0;
          default: ;
        endcase
      end
      drive();
      if (haveTx && cyc >= g + 3) haveTx = 1'b0;
      if (!haveTx) arbitrate();
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic midAccessReset(input bit holdReq);
    doReset(0);
    setReq(1, 1'b1, 16'h0001, 16'hCAFE);
    runCycles(1, 2);
    check("midPreEn", busEn, 1'b1);
    #2 rstn = 1'b0;
    if (!holdReq) begin st[1] = 0; mReq[1] = 1'b0; drive(); end
    #1;
    check("midRstEn", busEn, 1'b0);
    check("midRstZ", busData, 16'hzzzz);
    check("midRstAck", dAck, 1'b0);
    doReset(holdReq);
    runCycles(5, 2);
  endtask

  initial begin
    int expFirst;
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; mReq[m] = 1'b0; mWr[m] = 1'b0; mAddr[m] = 16'h0; mWdata[m] = 16'h0;
    end
    cyc = 0;
    drive();
    @(negedge clk);

    // both masters requesting across reset release
    newReq(0);
    newReq(1);
    doReset(1);
    order.delete();
    runCycles(6, 2);
`ifdef MEM_BUS_ARB_RR_EN
    expFirst = 0;
`else
    expFirst = 1;
`endif
    check("firstOwner", (order.size() > 0) ? order[0] : 9, expFirst);
    check("firstPairCount", order.size(), 2);

    doReset(0);
    setReq(0, 1'b0, 16'h0002, 16'h0000);
    runCycles(5, 2);
    check("readHold", cRdata, 16'h1234);

    setReq(1, 1'b1, 16'h0001, 16'hBEEF);
    runCycles(5, 2);

    doReset(0);
    order.delete();
    runCycles(30, 1);
    check("grantCount", order.size(), 10);
    for (int i = 0; i < 10 && i < order.size(); i++) begin
`ifdef MEM_BUS_ARB_RR_EN
      check("grantOrder", order[i], (i % 2 == 0) ? 0 : 1);
`else
      check("grantOrder", order[i], (i % 5 == 4) ? 0 : 1);
`endif
    end

    midAccessReset(1'b0);
    midAccessReset(1'b1);

    doReset(0);
    runCycles(3000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
